// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared state encodings and width helpers for switch_port
package switch_pkg;

    typedef enum logic [1:0] {T_IDLE, T_REQ, T_ACK} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_VALID, R_ACK} rx_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // A single destination still needs a one-bit address bus.
    function automatic int adr_width(input int nport);
        return (clog2(nport) < 1) ? 1 : clog2(nport);
    endfunction

endpackage

// File: rtl/switch_port_fifo.sv
// rtl/switch_port_fifo.sv - single-clock show-ahead FIFO with registered full/afull/empty/ovf
module switch_port_fifo #(
    parameter int DW    = 8,
    parameter int AW    = 3,
    parameter int AFULL = 2**AW - 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] wdata,
    input  logic          wen,
    input  logic          ren,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          afull,
    output logic          empty,
    output logic          ovf
);

    localparam int PW    = AW + 1;
    localparam int DEPTH = 2**AW;
    localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_L = PW'(AFULL);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr, rptr, wptr_n, rptr_n, occ_n;
    logic          do_read, do_write;

    // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign do_read  = ren && !empty;
    assign do_write = wen && (!full || do_read);
    assign wptr_n   = wptr + PW'(do_write);
    assign rptr_n   = rptr + PW'(do_read);
    assign occ_n    = wptr_n - rptr_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            full  <= 1'b0;
            afull <= 1'b0;
            empty <= 1'b1;
            ovf   <= 1'b0;
        end else begin
            wptr  <= wptr_n;
            rptr  <= rptr_n;
            full  <= (occ_n == DEPTH_L);
            afull <= (occ_n >= AFULL_L);
            empty <= (occ_n == '0);
            ovf   <= wen && !do_write;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/switch_port.sv
// rtl/switch_port.sv - switch port: TX req/gnt engine, RX FIFO with valid/ack; SWITCH_PORT_STATS_EN adds counters
module switch_port
    import switch_pkg::*;
#(
    parameter int DW    = 8,
    parameter int AW    = 3,
    parameter int NPORT = 4,
    parameter int AFULL = 2**AW - 2,
    parameter int CW    = 16,
    localparam int ADRW = adr_width(NPORT)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [DW-1:0]   dat_i,
    input  logic [ADRW-1:0] adr_i,
    input  logic            validtx,
    output logic            acktx,
    output logic            err,
    output logic            sw_req,
    output logic [DW-1:0]   sw_dat,
    output logic [ADRW-1:0] sw_adr,
    input  logic            sw_gnt,
    input  logic [DW-1:0]   fifo_i,
    input  logic            wen,
    output logic            full,
    output logic            afull,
    output logic            ovf,
    output logic [DW-1:0]   dat_o,
    output logic            validrx,
    input  logic            ackrx,
    output logic [CW-1:0]   tx_cnt,
    output logic [CW-1:0]   rx_cnt,
    output logic [CW-1:0]   drop_cnt
);

    localparam logic [ADRW:0] NPORT_L = (ADRW + 1)'(NPORT);

    tx_state_t tx_state, tx_next;
    rx_state_t rx_state, rx_next;
    logic      adr_ok, tx_load, ren, empty;

    assign adr_ok = ({1'b0, adr_i} < NPORT_L);

    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        case (tx_state)
            T_IDLE: if (validtx) begin
                tx_load = 1'b1;
                tx_next = adr_ok ? T_REQ : T_ACK;
            end
            T_REQ:   if (sw_gnt) tx_next = T_ACK;
            T_ACK:   if (!validtx) tx_next = T_IDLE;
            default: tx_next = T_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state <= T_IDLE;
            sw_dat   <= '0;
            sw_adr   <= '0;
            err      <= 1'b0;
        end else begin
            tx_state <= tx_next;
            if (tx_load) begin
                sw_dat <= dat_i;
                sw_adr <= adr_i;
            end
            err <= tx_load && !adr_ok;
        end
    end

    assign sw_req = (tx_state == T_REQ);
    assign acktx  = (tx_state == T_ACK);

    // R_ACK waits for ackrx to fall, so a long ack phase pops only once.
    always_comb begin
        rx_next = rx_state;
        ren     = 1'b0;
        case (rx_state)
            R_IDLE:  if (!empty) rx_next = R_VALID;
            R_VALID: if (ackrx) begin
                ren     = 1'b1;
                rx_next = R_ACK;
            end
            R_ACK:   if (!ackrx) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_state <= R_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    assign validrx = (rx_state == R_VALID);

    switch_port_fifo #(
        .DW    (DW),
        .AW    (AW),
        .AFULL (AFULL)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .wdata (fifo_i),
        .wen   (wen),
        .ren   (ren),
        .rdata (dat_o),
        .full  (full),
        .afull (afull),
        .empty (empty),
        .ovf   (ovf)
    );

`ifdef SWITCH_PORT_STATS_EN
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          tx_grant;
    logic [CW:0]   drop_sum;

    assign tx_grant = (tx_state == T_REQ) && sw_gnt;
    // err and ovf can coincide; both count, clamped at the ceiling.
    assign drop_sum = {1'b0, drop_cnt} + (CW + 1)'(err) + (CW + 1)'(ovf);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            if (tx_grant && tx_cnt != CNT_MAX) tx_cnt <= tx_cnt + 1'b1;
            if (ren && rx_cnt != CNT_MAX) rx_cnt <= rx_cnt + 1'b1;
            drop_cnt <= drop_sum[CW] ? CNT_MAX : drop_sum[CW-1:0];
        end
    end
`else
    assign tx_cnt   = '0;
    assign rx_cnt   = '0;
    assign drop_cnt = '0;
`endif

endmodule
